// File: rtl/spi_xfer_ctrl.sv
// Byte transfer sequencer between a host TX FIFO / RX register and an SPI master.
// Optional transfer counter output xfer_count is enabled by defining SPI_XFER_CNT_EN.
module spi_xfer_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned XFER_CYCLES = 16
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        tx_wr,
  input  logic [7:0]  tx_data,
  output logic        tx_full,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        busy,
  output logic        load_master,
  output logic        start,
  output logic        read_master,
  output logic [7:0]  data_in_master,
  input  logic [7:0]  data_out_master
`ifdef SPI_XFER_CNT_EN
  ,
  output logic [15:0] xfer_count
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SHF_W = (XFER_CYCLES > 2) ? $clog2(XFER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);
  localparam logic [SHF_W-1:0] SHF_LOAD = SHF_W'(XFER_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, SHIFT, READ, CAPT, HOLD} state_e;

  state_e           state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SHF_W-1:0] shf_q, shf_d;
  logic [7:0]       data_in_q, data_in_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             load_q, load_d, start_q, start_d, read_q, read_d;
  logic             busy_q, busy_d, full_q, full_d;
  logic             push, pop;
`ifdef SPI_XFER_CNT_EN
  logic [15:0]      xfer_cnt_q, xfer_cnt_d;
`endif

  // Next-state, FIFO bookkeeping and registered strobe decode
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    shf_d      = shf_q;
    data_in_d  = data_in_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    pop        = 1'b0;
    push       = 1'b0;
`ifdef SPI_XFER_CNT_EN
    xfer_cnt_d = xfer_cnt_q;
`endif

    case (state_q)
      IDLE:  if ((count_q != '0) && !rx_valid_q) state_d = LOAD;
      LOAD:  begin
        pop     = 1'b1;
        state_d = START;
      end
      START: begin
        shf_d   = SHF_LOAD;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (shf_q == '0) state_d = READ;
        else             shf_d   = shf_q - SHF_W'(1);
      end
      READ:  state_d = CAPT;
      CAPT:  begin
        rx_data_d  = data_out_master;
        rx_valid_d = 1'b1;
        state_d    = HOLD;
`ifdef SPI_XFER_CNT_EN
        xfer_cnt_d = xfer_cnt_q + 16'd1;
`endif
      end
      HOLD:  begin
        if (rx_valid_q && rx_ready) begin
          rx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A write while full is still taken when the head is leaving this cycle
    push = tx_wr && ((count_q != FULL_LVL) || pop);

    if (push) begin
      mem_d[wr_ptr_q] = tx_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    if (state_d == LOAD) data_in_d = mem_q[rd_ptr_q];

    load_d  = (state_d == LOAD);
    start_d = (state_d == START);
    read_d  = (state_d == READ);
    busy_d  = (state_d != IDLE);
    full_d  = (count_d == FULL_LVL);
  end

  always_ff @(posedge mclk) begin
    if (!reset) begin
      state_q    <= IDLE;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shf_q      <= '0;
      data_in_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      load_q     <= 1'b0;
      start_q    <= 1'b0;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
`ifdef SPI_XFER_CNT_EN
      xfer_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shf_q      <= shf_d;
      data_in_q  <= data_in_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      load_q     <= load_d;
      start_q    <= start_d;
      read_q     <= read_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
`ifdef SPI_XFER_CNT_EN
      xfer_cnt_q <= xfer_cnt_d;
`endif
    end
  end

  assign tx_full        = full_q;
  assign rx_valid       = rx_valid_q;
  assign rx_data        = rx_data_q;
  assign busy           = busy_q;
  assign load_master    = load_q;
  assign start          = start_q;
  assign read_master    = read_q;
  assign data_in_master = data_in_q;
`ifdef SPI_XFER_CNT_EN
  assign xfer_count     = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: timing, back-pressure, overflow, reset abort, random traffic.
module tb_spi_xfer_ctrl;

  logic       mclk = 1'b0;
  logic       reset, tx_wr, rx_ready;
  logic [7:0] tx_data, data_out_master;
  logic       tx_full, rx_valid, busy, load_master, start, read_master;
  logic [7:0] rx_data, data_in_master;
`ifdef SPI_XFER_CNT_EN
  logic [15:0] xfer_count;
`endif

  spi_xfer_ctrl #(.FIFO_DEPTH(4), .XFER_CYCLES(16)) dut (
    .mclk(mclk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .busy(busy),
    .load_master(load_master), .start(start), .read_master(read_master),
    .data_in_master(data_in_master), .data_out_master(data_out_master)
`ifdef SPI_XFER_CNT_EN
    , .xfer_count(xfer_count)
`endif
  );

  always #5 mclk = ~mclk;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int loads = 0, reads = 0, multi = 0;
  logic [7:0] mosi [$];

  // Bus monitor sampled mid-cycle
  always @(negedge mclk) begin
    if (load_master) begin
      mosi.push_back(data_in_master);
      loads++;
    end
    if (read_master) reads++;
    if ((int'(load_master) + int'(start) + int'(read_master)) > 1) multi++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!rx_valid && k < 100) begin
      tick();
      k++;
    end
    check(tag, 16'(rx_valid), 16'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_strobes"}, {13'd0, load_master, start, read_master}, 16'd0);
    check({tag, "_din"}, 16'(data_in_master), 16'h00);
    check({tag, "_rxv"}, 16'(rx_valid), 16'd0);
    check({tag, "_rxd"}, 16'(rx_data), 16'h00);
    check({tag, "_busy"}, 16'(busy), 16'd0);
    check({tag, "_full"}, 16'(tx_full), 16'd0);
  endtask

  initial begin
    logic [7:0] exp_b [7];
    logic [7:0] expq [$];
    int lb, mb, r0, l0, sent, bad, rb;
    logic [7:0] b;
    exp_b = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07};

    reset = 1'b0; tx_wr = 1'b0; tx_data = '0; rx_ready = 1'b0; data_out_master = '0;
    tick(); tick();
    check_zero("rst");
`ifdef SPI_XFER_CNT_EN
    check("rst_xcnt", xfer_count, 16'd0);
`endif

    // Single byte: write lands on edge 0
    reset = 1'b1; rx_ready = 1'b1; data_out_master = 8'h3C;
    tx_wr = 1'b1; tx_data = 8'hA5;
    tick(); tx_wr = 1'b0;
    check("c0_busy", 16'(busy), 16'd0);
    tick();
    check("c1_load", {13'd0, load_master, start, read_master}, 16'b100);
    check("c1_din", 16'(data_in_master), 16'hA5);
    tick();
    check("c2_start", {13'd0, load_master, start, read_master}, 16'b010);
    for (int c = 3; c <= 18; c++) begin
      tick();
      check("shift_strobes", {13'd0, load_master, start, read_master}, 16'b000);
      check("shift_hold", {7'd0, busy, data_in_master}, {7'd0, 1'b1, 8'hA5});
    end
    tick();
    check("c19_read", {13'd0, load_master, start, read_master}, 16'b001);
    tick();
    check("c20_rxv", {15'd0, rx_valid}, 16'd0);
    tick();
    check("c21_rxv", 16'(rx_valid), 16'd1);
    check("c21_rxd", 16'(rx_data), 16'h3C);
    tick();
    check("c22_clear", {14'd0, rx_valid, busy}, 16'd0);

    // Back-pressure and overflow
    lb = loads; mb = mosi.size();
    rx_ready = 1'b0; data_out_master = 8'hC1;
    tx_wr = 1'b1; tx_data = 8'h55;
    tick(); tx_wr = 1'b0;
    wait_valid("bp_hold1");
    check("bp_rxd1", 16'(rx_data), 16'hC1);
    for (int i = 1; i <= 4; i++) begin
      tx_wr = 1'b1; tx_data = 8'(i);
      tick();
    end
    tx_wr = 1'b0;
    check("bp_full4", 16'(tx_full), 16'd1);
    check("bp_busy", 16'(busy), 16'd1);
    tx_wr = 1'b1; tx_data = 8'h05;
    tick(); tx_wr = 1'b0;
    check("ovf_full", 16'(tx_full), 16'd1);
    repeat (5) tick();
    check("bp_noload", 16'(loads - lb), 16'd1);
    data_out_master = 8'hC2;
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    check("bp_idle", {14'd0, rx_valid, busy}, 16'd0);
    check("bp_idle_full", 16'(tx_full), 16'd1);
    tick();
    check("bp_load01", {7'd0, load_master, data_in_master}, {7'd0, 1'b1, 8'h01});
    tick();
    check("bp_drop_full", 16'(tx_full), 16'd0);
    wait_valid("bp_hold2");
    check("bp_rxd2", 16'(rx_data), 16'hC2);
    tx_wr = 1'b1; tx_data = 8'h06;
    tick(); tx_wr = 1'b0;
    check("bp_refull", 16'(tx_full), 16'd1);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    tick();
    check("bp_load02", {7'd0, load_master, data_in_master}, {7'd0, 1'b1, 8'h02});
    tx_wr = 1'b1; tx_data = 8'h07;
    tick(); tx_wr = 1'b0;
    check("wr_pop_full", 16'(tx_full), 16'd1);
    rx_ready = 1'b1;
    for (int k = 0; k < 400 && !((loads - lb) == 7 && !busy); k++) tick();
    check("bp_nloads", 16'(loads - lb), 16'd7);
    check("bp_drained", {14'd0, busy, tx_full}, 16'd0);
    bad = 0;
    for (int i = 0; i < 7; i++)
      if ((mb + i) >= mosi.size() || mosi[mb + i] !== exp_b[i]) bad++;
    check("mosi_seq", 16'(bad), 16'd0);

    // Reset while the counter is at 7
    data_out_master = 8'h77;
    tx_wr = 1'b1; tx_data = 8'h9E;
    tick(); tx_wr = 1'b0;
    repeat (11) tick();
    check("mid_state", {7'd0, busy, data_in_master}, {7'd0, 1'b1, 8'h9E});
    r0 = reads; l0 = loads;
    reset = 1'b0;
    tick();
    check_zero("mid_rst");
`ifdef SPI_XFER_CNT_EN
    check("mid_xcnt", xfer_count, 16'd0);
`endif
    reset = 1'b1;
    repeat (40) tick();
    check("abort_noread", 16'(reads - r0), 16'd0);
    check("abort_noload", 16'(loads - l0), 16'd0);
    check("abort_idle", 16'(busy), 16'd0);

    // Random traffic, 1000 bytes
    mb = mosi.size(); rb = reads; sent = 0;
    for (int cyc = 0; cyc < 80000 && (sent < 1000 || (reads - rb) < 1000 || busy); cyc++) begin
      if (sent < 1000 && !tx_full && $urandom_range(0, 3) != 0) begin
        b = 8'($urandom);
        tx_wr = 1'b1; tx_data = b;
        expq.push_back(b);
        sent++;
      end else begin
        tx_wr = 1'b0;
      end
      rx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    tx_wr = 1'b0; rx_ready = 1'b1;
    tick();
    check("rnd_sent", 16'(sent), 16'd1000);
    check("rnd_reads", 16'(reads - rb), 16'd1000);
    bad = 0;
    for (int i = 0; i < expq.size(); i++)
      if ((mb + i) >= mosi.size() || mosi[mb + i] !== expq[i]) bad++;
    check("rnd_mosi", 16'(bad), 16'd0);
    check("strobe_excl", 16'(multi), 16'd0);
`ifdef SPI_XFER_CNT_EN
    check("rnd_xcnt", xfer_count, 16'd1000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
